// File: rtl/camera_pkg.sv
// Shared types for the camera coordinate tagger: tagger state and line-length width rule.
package camera_pkg;

  typedef enum logic [0:0] {
    ST_LOCK = 1'b0,
    ST_RUN  = 1'b1
  } cam_state_t;

  // One extra bit so that a completely full 2^H_W pixel line is still representable.
  localparam int LINE_LEN_EXTRA = 1;

  function automatic int line_len_w(input int h_w);
    return h_w + LINE_LEN_EXTRA;
  endfunction

endpackage

// File: rtl/camera_coord_gen_if.sv
// Pixel stream in, tagged pixel stream out, for the camera coordinate tagger.
interface camera_coord_gen_if #(
  parameter int DATA_W  = 16,
  parameter int H_W     = 11,
  parameter int V_W     = 10,
  parameter int FRAME_W = 8
);
  localparam int LEN_W = camera_pkg::line_len_w(H_W);

  logic               valid_in;
  logic [DATA_W-1:0]  data_in;
  logic               hsync_in;
  logic               vsync_in;

  logic               valid_out;
  logic [DATA_W-1:0]  data_out;
  logic [H_W-1:0]     hcount_out;
  logic [V_W-1:0]     vcount_out;
  logic               frame_start_out;
  logic               line_start_out;
  logic [FRAME_W-1:0] frame_count_out;
  logic [LEN_W-1:0]   line_len_out;
  logic               line_len_valid_out;
  logic               h_ovf_out;
  logic               v_ovf_out;

  modport master (
    output valid_in, data_in, hsync_in, vsync_in,
    input  valid_out, data_out, hcount_out, vcount_out, frame_start_out, line_start_out,
           frame_count_out, line_len_out, line_len_valid_out, h_ovf_out, v_ovf_out
  );

  modport slave (
    input  valid_in, data_in, hsync_in, vsync_in,
    output valid_out, data_out, hcount_out, vcount_out, frame_start_out, line_start_out,
           frame_count_out, line_len_out, line_len_valid_out, h_ovf_out, v_ovf_out
  );
endinterface

// File: rtl/sync_edge.sv
// Normalises a sync level to active-high and detects qualified edges against the
// last level seen on an enabled cycle.
module sync_edge #(
  parameter logic ACT = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic sync,
  output logic level,
  output logic rise,
  output logic fall
);
  logic prev_r;

  assign level = (sync == ACT);
  assign rise  = en & level & ~prev_r;
  assign fall  = en & ~level & prev_r;

  // Last qualified level; starts inactive so a sync already active at reset reads as a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r <= 1'b0;
    end else if (en) begin
      prev_r <= level;
    end
  end
endmodule

// File: rtl/camera_coord_gen.sv
// Tags camera pixels with hcount/vcount after locking onto the first complete frame,
// and reports line length, frame count and sticky overflow flags.
module camera_coord_gen
  import camera_pkg::*;
#(
  parameter int   DATA_W    = 16,
  parameter int   H_W       = 11,
  parameter int   V_W       = 10,
  parameter int   FRAME_W   = 8,
  parameter logic HSYNC_ACT = 1'b1,
  parameter logic VSYNC_ACT = 1'b1
) (
  input logic              clk_in,
  input logic              rst_in,
  camera_coord_gen_if.slave bus
);
  localparam int LEN_W = line_len_w(H_W);
  localparam logic [LEN_W-1:0]   LEN_ZERO   = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0]   LEN_ONE    = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [V_W-1:0]     ROW_ZERO   = {V_W{1'b0}};
  localparam logic [V_W-1:0]     ROW_ONE    = {{(V_W-1){1'b0}}, 1'b1};
  localparam logic [V_W-1:0]     ROW_MAX    = {V_W{1'b1}};
  localparam logic [FRAME_W-1:0] FRAME_ZERO = {FRAME_W{1'b0}};
  localparam logic [FRAME_W-1:0] FRAME_ONE  = {{(FRAME_W-1){1'b0}}, 1'b1};

  logic hs_s, vs_s, hs_fall_s, vs_fall_s;
  logic unused_hs_rise_s, unused_vs_rise_s;
  logic line_full_s;

  cam_state_t       state_r;
  logic [LEN_W-1:0] pixel_cnt_r;
  logic [V_W-1:0]   row_r;

  sync_edge #(.ACT(HSYNC_ACT)) u_hs_edge (
    .clk   (clk_in),
    .rst_n (rst_in),
    .en    (bus.valid_in),
    .sync  (bus.hsync_in),
    .level (hs_s),
    .rise  (unused_hs_rise_s),
    .fall  (hs_fall_s)
  );

  sync_edge #(.ACT(VSYNC_ACT)) u_vs_edge (
    .clk   (clk_in),
    .rst_n (rst_in),
    .en    (bus.valid_in),
    .sync  (bus.vsync_in),
    .level (vs_s),
    .rise  (unused_vs_rise_s),
    .fall  (vs_fall_s)
  );

  // The top bit of the pixel counter is set once hcount 2^H_W-1 has gone out.
  assign line_full_s = pixel_cnt_r[H_W];

  // Lock/run state machine with all tagged outputs registered; vs fall outranks hs fall.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r                <= ST_LOCK;
      pixel_cnt_r            <= LEN_ZERO;
      row_r                  <= ROW_ZERO;
      bus.valid_out          <= 1'b0;
      bus.data_out           <= {DATA_W{1'b0}};
      bus.hcount_out         <= {H_W{1'b0}};
      bus.vcount_out         <= ROW_ZERO;
      bus.frame_start_out    <= 1'b0;
      bus.line_start_out     <= 1'b0;
      bus.frame_count_out    <= FRAME_ZERO;
      bus.line_len_out       <= LEN_ZERO;
      bus.line_len_valid_out <= 1'b0;
      bus.h_ovf_out          <= 1'b0;
      bus.v_ovf_out          <= 1'b0;
    end else begin
      bus.valid_out          <= 1'b0;
      bus.frame_start_out    <= 1'b0;
      bus.line_start_out     <= 1'b0;
      bus.line_len_valid_out <= 1'b0;
      if (bus.valid_in) begin
        case (state_r)
          ST_LOCK: begin
            if (vs_fall_s) begin
              pixel_cnt_r <= LEN_ZERO;
              row_r       <= ROW_ZERO;
              state_r     <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (vs_fall_s) begin
              bus.line_len_out       <= pixel_cnt_r;
              bus.line_len_valid_out <= (pixel_cnt_r != LEN_ZERO);
              bus.frame_count_out    <= bus.frame_count_out + FRAME_ONE;
              pixel_cnt_r            <= LEN_ZERO;
              row_r                  <= ROW_ZERO;
              bus.h_ovf_out          <= 1'b0;
              bus.v_ovf_out          <= 1'b0;
            end else if (hs_fall_s) begin
              bus.line_len_out       <= pixel_cnt_r;
              bus.line_len_valid_out <= 1'b1;
              pixel_cnt_r            <= LEN_ZERO;
              if (row_r == ROW_MAX) begin
                bus.v_ovf_out <= 1'b1;
              end else begin
                row_r <= row_r + ROW_ONE;
              end
            end else if (hs_s && vs_s) begin
              if (!line_full_s) begin
                bus.valid_out       <= 1'b1;
                bus.data_out        <= bus.data_in;
                bus.hcount_out      <= pixel_cnt_r[H_W-1:0];
                bus.vcount_out      <= row_r;
                bus.line_start_out  <= (pixel_cnt_r == LEN_ZERO);
                bus.frame_start_out <= (pixel_cnt_r == LEN_ZERO) && (row_r == ROW_ZERO);
                pixel_cnt_r         <= pixel_cnt_r + LEN_ONE;
              end else begin
                bus.h_ovf_out <= 1'b1;
              end
            end
          end
          default: begin
            state_r <= ST_LOCK;
          end
        endcase
      end
    end
  end
endmodule

// File: doc/camera_coord_gen.md
Name: camera_coord_gen

Overview:
Parametrised pixel-coordinate tagger for the camera capture path. It sits between the camera byte-to-pixel stage and frame storage. It converts a pixel-enable stream plus line/frame sync levels into pixels tagged with hcount/vcount. It adds configurable sync polarity, frame lock-on after reset, frame and line start markers, a measured line length, a frame counter, and sticky overflow flags.

Parameters:
DATA_W, 16, pixel data width
H_W, 11, hcount width
V_W, 10, vcount width
FRAME_W, 8, frame counter width (wraps)
HSYNC_ACT, 1'b1, hsync_in level meaning "line active"
VSYNC_ACT, 1'b1, vsync_in level meaning "frame active"

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-low (asserted when 0)
valid_in  input  1  pixel-clock enable; all sync and data sampling is qualified by it
data_in  input  DATA_W  pixel data
hsync_in  input  1  line-active level (polarity per HSYNC_ACT)
vsync_in  input  1  frame-active level (polarity per VSYNC_ACT)
valid_out  output  1  tagged pixel valid
data_out  output  DATA_W  pixel data
hcount_out  output  H_W  pixel column, first pixel of a line = 0
vcount_out  output  V_W  pixel row, first line of a frame = 0
frame_start_out  output  1  high with the pixel at (0,0)
line_start_out  output  1  high with every pixel at hcount 0
frame_count_out  output  FRAME_W  completed-frame count
line_len_out  output  H_W+1  pixel count of the most recently ended line
line_len_valid_out  output  1  one-cycle pulse when line_len_out updates
h_ovf_out  output  1  sticky: a line exceeded 2^H_W pixels in the current frame
v_ovf_out  output  1  sticky: a frame exceeded 2^V_W lines

Behaviour:
- Reset (rst_in=0, async): all outputs 0. hs_prev/vs_prev are set to the inactive level. State is LOCK. Internal pixel/line counters are 0.
- Internally, hs = (hsync_in==HSYNC_ACT) and vs = (vsync_in==VSYNC_ACT). Edges are detected against the _prev registers. _prev registers update only on cycles with valid_in=1.
- Cycles with valid_in=0: valid_out, frame_start_out, line_start_out and line_len_valid_out are 0. All other state holds.
- States:
  - LOCK: emits no pixels. On vs falling edge (active->inactive): clear counters, go to RUN. This discards a partial frame after reset.
  - RUN: processes events and pixels as below.
- RUN event priority, per valid_in cycle:
  1. vs fall: line_len_out <= pixel_cnt; line_len_valid_out pulses if pixel_cnt != 0. frame_count_out += 1 (wraps). Row and pixel counters clear. h_ovf_out and v_ovf_out clear. No pixel is emitted.
  2. Else hs fall: line_len_out <= pixel_cnt; line_len_valid_out pulses. Row counter increments, saturating at 2^V_W-1; saturation sets v_ovf_out. Pixel counter clears. No pixel is emitted.
  3. Else hs && vs: emit the pixel.
     - valid_out=1, data_out=data_in, hcount_out=pixel_cnt, vcount_out=row.
     - line_start_out = (pixel_cnt==0). frame_start_out = (pixel_cnt==0 && row==0).
     - pixel_cnt increments, saturating at 2^H_W. When the pixel at hcount 2^H_W-1 has already been emitted, further pixels in that line are dropped (valid_out=0) and h_ovf_out is set.
  4. Else: no pixel.
- Latency: 1 cycle, registered, from the valid_in sample to all outputs.
- A simultaneous hs fall and vs fall is handled as a vs fall only. line_len still latches the last line.
- line_len_out is H_W+1 bits so that a full 2^H_W line is representable.
- Reset asserted mid-frame returns the block to LOCK. No pixel output until the next vs fall.

Decomposition:
- Shared package camera_pkg holds the state enum (LOCK, RUN) and the localparam for line-length width (H_W+1 rule).
- Natural sub-module: sync_edge. It holds the prev register, polarity normalise and valid qualification, and outputs level, rise and fall. It is instantiated once per sync.

Test Plan:
- Reset, then 2 lines of 4 pixels with no prior vs fall -> valid_out stays 0 (LOCK). After a vs fall, the next frame emits pixels.
- Locked, frame of 3 lines x 5 pixels (valid_in every cycle) -> 15 pixels with hcount 0..4 and vcount 0..2. frame_start_out only at (0,0). line_start_out 3 times. line_len_out=5 pulsed 3 times. frame_count_out 0->1 at vs fall.
- Same frame with valid_in toggling every other cycle, and syncs changing only on valid cycles -> identical tagged output. Outputs 0 on non-valid cycles.
- H_W=3, line of 10 pixels -> 8 pixels emitted (hcount 0..7), h_ovf_out=1, line_len_out=8. h_ovf_out cleared at the next vs fall.
- HSYNC_ACT=0, VSYNC_ACT=0, inverted stimulus of the 3x5 case -> same results. Simultaneous hs and vs fall -> frame_count increments once, vcount resets to 0.
- Reset pulse mid-line -> outputs 0 immediately (async). No pixels until the next vs fall. frame_count_out=0.
